interrupt_controller: RTL and testbench

Sequences external interrupt lines into the processor's interrupt entry. It edge-detects and latches requests, applies a software mask and fixed priority, and presents one request at a time with its vector address. It holds that request until the processor acknowledges it, then tracks the in-service interval until return-from-interrupt. It sits between the top-level interrupt pins and the processor, alongside the instruction and data memories.

---
 rtl/interrupt_controller.sv | 103 ++++++++++
 tb/tb_interrupt_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Edge-latching, maskable, fixed-priority interrupt sequencer.
// Presents one vectored request at a time and tracks its service interval.
module interrupt_controller #(
    parameter int                    NUM_IRQ    = 2,
    parameter int                    PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0]   VEC_BASE   = '0,
    parameter int                    VEC_STRIDE = 2,
    parameter logic [NUM_IRQ-1:0]    MASK_RST   = '0,
    localparam int                   IDW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic                mask_we,
    input  logic [NUM_IRQ-1:0]  mask_wdata,
    input  logic                cpu_int_ack,
    input  logic                cpu_rti,
    input  logic                ovr_clr,
    output logic                int_req,
    output logic [IDW-1:0]      int_id,
    output logic [PC_WIDTH-1:0] vector_addr,
    output logic                in_service,
    output logic [NUM_IRQ-1:0]  pending,
    output logic [NUM_IRQ-1:0]  overrun
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    logic [1:0]          state;
    logic [NUM_IRQ-1:0]  prevIrq;
    logic [NUM_IRQ-1:0]  mask;
    logic [NUM_IRQ-1:0]  irqEdge;
    logic [NUM_IRQ-1:0]  eligible;
    logic [NUM_IRQ-1:0]  ackClr;
    logic [IDW-1:0]      pickId;
    logic [PC_WIDTH-1:0] pickVec;
    logic                ackTake;
    logic                rtiTake;

    assign irqEdge  = irq_in & ~prevIrq;
    assign eligible = pending & ~mask;
    assign ackTake  = (state == REQ) && cpu_int_ack;
    // Simultaneous ack and rti counts as ack only, so rti needs ack low.
    assign rtiTake  = (state == SERVICE) && cpu_rti && !cpu_int_ack;
    assign ackClr   = ackTake ? (NUM_IRQ'(1) << int_id) : '0;
    assign int_req    = (state == REQ);
    assign in_service = (state == SERVICE);

    // Descending scan so the lowest eligible index is the last write.
    always_comb begin
        pickId = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                pickId = IDW'(i);
            end
        end
    end

    assign pickVec = VEC_BASE
                   + PC_WIDTH'(pickId) * PC_WIDTH'(VEC_STRIDE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            int_id      <= '0;
            vector_addr <= VEC_BASE;
            pending     <= '0;
            overrun     <= '0;
            mask        <= MASK_RST;
            prevIrq     <= '0;
        end else begin
            prevIrq <= irq_in;
            pending <= (pending & ~ackClr) | irqEdge;
            overrun <= (ovr_clr ? '0 : overrun) | (irqEdge & pending);
            if (mask_we) begin
                mask <= mask_wdata;
            end
            unique case (state)
                IDLE: begin
                    if (|eligible) begin
                        state       <= REQ;
                        int_id      <= pickId;
                        vector_addr <= pickVec;
                    end
                end
                REQ: begin
                    if (ackTake) begin
                        state <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (rtiTake) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomized scoreboard bench for interrupt_controller.
// Stimulus updates a line-level model; a monitor compares every cycle.
module tb_interrupt_controller;

    localparam int NIRQ = 2;
    localparam int PCW  = 32;
    localparam int VS   = 2;
    localparam logic [PCW-1:0] VB = '0;

    logic            clk = 1'b0;
    logic            reset;
    logic [NIRQ-1:0] irq_in;
    logic            mask_we;
    logic [NIRQ-1:0] mask_wdata;
    logic            cpu_int_ack;
    logic            cpu_rti;
    logic            ovr_clr;
    logic            int_req;
    logic            int_id;
    logic [PCW-1:0]  vector_addr;
    logic            in_service;
    logic [NIRQ-1:0] pending;
    logic [NIRQ-1:0] overrun;

    interrupt_controller #(
        .NUM_IRQ(NIRQ), .PC_WIDTH(PCW), .VEC_BASE(VB),
        .VEC_STRIDE(VS), .MASK_RST('0)
    ) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in),
        .mask_we(mask_we), .mask_wdata(mask_wdata),
        .cpu_int_ack(cpu_int_ack), .cpu_rti(cpu_rti),
        .ovr_clr(ovr_clr), .int_req(int_req), .int_id(int_id),
        .vector_addr(vector_addr), .in_service(in_service),
        .pending(pending), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            req;
        bit            srv;
        int            id;
        bit [PCW-1:0]  vec;
        bit [NIRQ-1:0] pend;
        bit [NIRQ-1:0] ovr;
    } snap_t;

    snap_t expQ[$];
    int    reqQ[$];
    int    checks = 0;
    int    errors = 0;

    bit [NIRQ-1:0] mPend, mOvr, mMask, mPrev;
    bit            mReq, mSrv;
    int            mId;

    function automatic bit [PCW-1:0] vecOf(int id);
        return VB + PCW'(id * VS);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic void mReset();
        mPend = '0; mOvr = '0; mMask = '0; mPrev = '0;
        mReq = 0; mSrv = 0; mId = 0;
    endfunction

    // Line-by-line model of one clock edge.
    task automatic step(input bit [NIRQ-1:0] irq, input bit we,
                        input bit [NIRQ-1:0] wd, input bit ack,
                        input bit rti, input bit clr, output bit newReq);
        bit [NIRQ-1:0] np;
        bit [NIRQ-1:0] no;
        int pick;
        np = mPend; no = mOvr; pick = -1; newReq = 0;
        for (int i = 0; i < NIRQ; i++) begin
            bit e;
            e = irq[i] && !mPrev[i];
            if (pick < 0 && mPend[i] && !mMask[i]) pick = i;
            if (e && mPend[i]) no[i] = 1;
            else if (clr) no[i] = 0;
            if (mReq && ack && mId == i) np[i] = 0;
            if (e) np[i] = 1;
        end
        if (mReq) begin
            if (ack) begin mReq = 0; mSrv = 1; end
        end else if (mSrv) begin
            if (rti && !ack) mSrv = 0;
        end else if (pick >= 0) begin
            mReq = 1; mId = pick; newReq = 1;
        end
        mPend = np; mOvr = no; mPrev = irq;
        if (we) mMask = wd;
    endtask

    task automatic cyc(input bit [NIRQ-1:0] irq, input bit we,
                       input bit [NIRQ-1:0] wd, input bit ack,
                       input bit rti, input bit clr);
        bit nr;
        irq_in = irq; mask_we = we; mask_wdata = wd;
        cpu_int_ack = ack; cpu_rti = rti; ovr_clr = clr;
        step(irq, we, wd, ack, rti, clr, nr);
        @(posedge clk);
        expQ.push_back('{mReq, mSrv, mId, vecOf(mId), mPend, mOvr});
        if (nr) reqQ.push_back(mId);
        #1;
    endtask

    task automatic chkReset(string tag);
        chk({tag, "_req"}, int_req, 0);
        chk({tag, "_srv"}, in_service, 0);
        chk({tag, "_id"}, int_id, 0);
        chk({tag, "_vec"}, vector_addr, VB);
        chk({tag, "_pend"}, pending, 0);
        chk({tag, "_ovr"}, overrun, 0);
    endtask

    // Monitor: compares DUT state after each edge with the queued model.
    initial begin
        bit lastReq;
        snap_t e;
        int id;
        lastReq = 0;
        forever begin
            @(posedge clk);
            #3;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("int_req", int_req, e.req);
                chk("in_service", in_service, e.srv);
                chk("int_id", int_id, e.id);
                chk("vector_addr", vector_addr, e.vec);
                chk("pending", pending, e.pend);
                chk("overrun", overrun, e.ovr);
                if (int_req && !lastReq) begin
                    if (reqQ.size() == 0) begin
                        chk("req_expected", 1, 0);
                    end else begin
                        id = reqQ.pop_front();
                        chk("req_event_id", int_id, id);
                        chk("req_event_vec", vector_addr, vecOf(id));
                    end
                end
            end
            lastReq = int_req;
        end
    end

    initial begin
        int n;
        bit [NIRQ-1:0] irq;
        reset = 0; irq_in = '0; mask_we = 0; mask_wdata = '0;
        cpu_int_ack = 0; cpu_rti = 0; ovr_clr = 0;
        mReset();
        #2;
        chkReset("rst0");
        @(posedge clk); #1;
        irq_in = 2'b11;
        #1;
        chkReset("rst_hold");
        reset = 1;

        // Both lines high through release: priority then second line.
        repeat (3) cyc(2'b11, 0, 0, 0, 0, 0);
        cyc(2'b11, 0, 0, 1, 0, 0);
        repeat (2) cyc(2'b11, 0, 0, 0, 0, 0);
        cyc(2'b11, 0, 0, 0, 1, 0);
        repeat (2) cyc(2'b11, 0, 0, 0, 0, 0);
        cyc(2'b00, 0, 0, 1, 0, 0);
        cyc(2'b00, 0, 0, 0, 1, 0);
        repeat (2) cyc(2'b00, 0, 0, 0, 0, 0);

        // Masked line latches but is not raised until unmasked.
        cyc(2'b00, 1, 2'b01, 0, 0, 0);
        cyc(2'b01, 0, 0, 0, 0, 0);
        repeat (3) cyc(2'b01, 0, 0, 0, 0, 0);
        cyc(2'b00, 1, 2'b00, 0, 0, 0);
        repeat (3) cyc(2'b00, 0, 0, 0, 0, 0);
        cyc(2'b00, 0, 0, 1, 0, 0);
        cyc(2'b00, 0, 0, 0, 1, 0);

        // Overrun, coalescing, stability and no nesting.
        cyc(2'b10, 0, 0, 0, 0, 0);
        cyc(2'b00, 0, 0, 0, 0, 0);
        cyc(2'b10, 0, 0, 0, 0, 0);
        cyc(2'b11, 0, 0, 0, 0, 0);
        repeat (2) cyc(2'b11, 0, 0, 0, 0, 0);
        cyc(2'b00, 0, 0, 1, 0, 0);
        cyc(2'b01, 0, 0, 0, 0, 1);
        repeat (2) cyc(2'b00, 0, 0, 0, 0, 0);
        cyc(2'b00, 0, 0, 1, 1, 0);
        cyc(2'b00, 0, 0, 0, 1, 0);
        repeat (3) cyc(2'b00, 0, 0, 0, 0, 0);
        cyc(2'b00, 0, 0, 1, 0, 0);
        cyc(2'b00, 0, 0, 0, 1, 0);

        // Randomized traffic, including spurious ack/rti pulses.
        irq = '0;
        for (int k = 0; k < 3000; k++) begin
            bit we, ack, rti, clr;
            bit [NIRQ-1:0] wd;
            for (int i = 0; i < NIRQ; i++) begin
                if ($urandom_range(3) == 0) irq[i] = ~irq[i];
            end
            we  = ($urandom_range(15) == 0);
            wd  = NIRQ'($urandom);
            ack = mReq ? ($urandom_range(2) == 0)
                       : ($urandom_range(19) == 0);
            rti = mSrv ? ($urandom_range(3) == 0)
                       : ($urandom_range(19) == 0);
            clr = ($urandom_range(15) == 0);
            cyc(irq, we, wd, ack, rti, clr);
        end

        // Drive towards a live request, then reset asynchronously.
        cyc(2'b00, 1, 2'b00, 0, 1, 0);
        n = 0;
        while (!mReq && n < 20) begin
            cyc((n % 2 == 0) ? 2'b10 : 2'b00, 0, 0, 0, 1, 0);
            n++;
        end
        chk("reach_req", mReq, 1);
        #3;
        reset = 0;
        #1;
        chkReset("rst_mid");
        mReset();
        reqQ.delete();
        irq_in = 2'b11;
        @(posedge clk); #1;
        chkReset("rst_mid_hold");
        reset = 1;
        repeat (3) cyc(2'b11, 0, 0, 0, 0, 0);
        cyc(2'b11, 0, 0, 1, 0, 0);
        cyc(2'b11, 0, 0, 0, 1, 0);
        repeat (3) cyc(2'b00, 0, 0, 0, 0, 0);

        @(posedge clk); #4;
        chk("expq_drain", expQ.size(), 0);
        chk("reqq_drain", reqQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
